// File: rtl/hdu.sv
// Hazard detection / pipeline control: load-use stalls, branch flushes and data-memory freeze with timeout watchdog.
// Optional performance counters are built when HDU_PERF_CNT_EN is defined.
`ifndef RF_ADDR_WIDTH
`define RF_ADDR_WIDTH 5
`endif

module hdu #(
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic [`RF_ADDR_WIDTH-1:0] ifidRs1,
  input  logic [`RF_ADDR_WIDTH-1:0] ifidRs2,
  input  logic                      ifidUsesRs2,
  input  logic [`RF_ADDR_WIDTH-1:0] idexRd,
  input  logic                      idexMemRead,
  input  logic                      exBranchTaken,
  input  logic                      exmemMemReq,
  input  logic                      dmemReady,
  output logic                      pcWrite,
  output logic                      ifidWrite,
  output logic                      idexBubble,
  output logic                      ifidFlush,
  output logic                      idexFlush,
  output logic                      pipeFreeze,
  output logic                      memTimeout
`ifdef HDU_PERF_CNT_EN
  ,
  output logic [31:0]               stallCycles,
  output logic [31:0]               flushCount
`endif
);

  localparam int unsigned RegW  = `RF_ADDR_WIDTH;
  localparam int unsigned WaitW = 16;

  typedef enum logic [1:0] {
    sRun  = 2'd0,
    sWait = 2'd1,
    sErr  = 2'd2
  } state_t;

  state_t           state, stateNext;
  logic [WaitW-1:0] waitCnt, waitCntNext;
  logic             memTimeoutNext;
  logic             memBusy;
  logic             loadUse;

  assign memBusy = exmemMemReq && !dmemReady;
  assign loadUse = idexMemRead && (idexRd != RegW'(0)) &&
                   ((idexRd == ifidRs1) || (ifidUsesRs2 && (idexRd == ifidRs2)));

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state      <= sRun;
      waitCnt    <= '0;
      memTimeout <= 1'b0;
    end else begin
      state      <= stateNext;
      waitCnt    <= waitCntNext;
      memTimeout <= memTimeoutNext;
    end
  end

  // Next state plus zero-latency control outputs; freeze outranks flush outranks stall.
  always_comb begin
    stateNext      = state;
    waitCntNext    = waitCnt;
    memTimeoutNext = memTimeout;
    pcWrite        = 1'b1;
    ifidWrite      = 1'b1;
    idexBubble     = 1'b0;
    ifidFlush      = 1'b0;
    idexFlush      = 1'b0;
    pipeFreeze     = 1'b0;

    case (state)
      sRun: begin
        if (memBusy) begin
          stateNext   = sWait;
          waitCntNext = WaitW'(1);
        end
      end
      sWait: begin
        if (dmemReady) begin
          stateNext   = sRun;
          waitCntNext = '0;
        end else if (waitCnt == WaitW'(MEM_TIMEOUT)) begin
          stateNext      = sErr;
          memTimeoutNext = 1'b1;
        end else begin
          waitCntNext = waitCnt + WaitW'(1);
        end
      end
      sErr: begin
        stateNext = sErr;
      end
      default: begin
        stateNext = sRun;
      end
    endcase

    if (!rstn) begin
      pcWrite   = 1'b0;
      ifidWrite = 1'b0;
      ifidFlush = 1'b1;
      idexFlush = 1'b1;
    end else if ((state == sErr) || memBusy) begin
      pipeFreeze = 1'b1;
      pcWrite    = 1'b0;
      ifidWrite  = 1'b0;
    end else if (exBranchTaken) begin
      ifidFlush = 1'b1;
      idexFlush = 1'b1;
    end else if (loadUse) begin
      pcWrite    = 1'b0;
      ifidWrite  = 1'b0;
      idexBubble = 1'b1;
    end
  end

`ifdef HDU_PERF_CNT_EN
  // Free-running wrap-around event counters.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      stallCycles <= '0;
      flushCount  <= '0;
    end else begin
      if (!pcWrite)  stallCycles <= stallCycles + 32'd1;
      if (ifidFlush) flushCount  <= flushCount + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hdu.sv
// Directed self-checking bench for hdu, built with MEM_TIMEOUT = 4.
`ifndef RF_ADDR_WIDTH
`define RF_ADDR_WIDTH 5
`endif

module tb_hdu;

  localparam logic [6:0] NORMAL  = 7'b1100000;
  localparam logic [6:0] STALL   = 7'b0010000;
  localparam logic [6:0] FLUSH   = 7'b1101100;
  localparam logic [6:0] FREEZE  = 7'b0000010;
  localparam logic [6:0] RSTOUT  = 7'b0001100;
  localparam logic [6:0] ERROUT  = 7'b0000011;

  logic clk = 1'b0;
  logic rstn;
  logic [`RF_ADDR_WIDTH-1:0] ifidRs1, ifidRs2, idexRd;
  logic ifidUsesRs2, idexMemRead, exBranchTaken, exmemMemReq, dmemReady;
  logic pcWrite, ifidWrite, idexBubble, ifidFlush, idexFlush, pipeFreeze, memTimeout;
`ifdef HDU_PERF_CNT_EN
  logic [31:0] stallCycles, flushCount;
`endif
  logic [6:0] ctl;

  int testsRun = 0;
  int testsFailed = 0;

  always #5 clk = ~clk;

  assign ctl = {pcWrite, ifidWrite, idexBubble, ifidFlush, idexFlush, pipeFreeze, memTimeout};

  hdu #(.MEM_TIMEOUT(4)) dut (
    .clk(clk), .rstn(rstn),
    .ifidRs1(ifidRs1), .ifidRs2(ifidRs2), .ifidUsesRs2(ifidUsesRs2),
    .idexRd(idexRd), .idexMemRead(idexMemRead),
    .exBranchTaken(exBranchTaken), .exmemMemReq(exmemMemReq), .dmemReady(dmemReady),
    .pcWrite(pcWrite), .ifidWrite(ifidWrite), .idexBubble(idexBubble),
    .ifidFlush(ifidFlush), .idexFlush(idexFlush), .pipeFreeze(pipeFreeze),
    .memTimeout(memTimeout)
`ifdef HDU_PERF_CNT_EN
    , .stallCycles(stallCycles), .flushCount(flushCount)
`endif
  );

  // Apply one cycle of inputs at the falling edge and settle before checking.
  task automatic drive(input logic rn, input int rs1, input int rs2, input logic uses,
                       input int rd, input logic mrd, input logic br,
                       input logic req, input logic rdy);
    @(negedge clk);
    rstn          = rn;
    ifidRs1       = `RF_ADDR_WIDTH'(rs1);
    ifidRs2       = `RF_ADDR_WIDTH'(rs2);
    ifidUsesRs2   = uses;
    idexRd        = `RF_ADDR_WIDTH'(rd);
    idexMemRead   = mrd;
    exBranchTaken = br;
    exmemMemReq   = req;
    dmemReady     = rdy;
    #1;
  endtask

  task automatic test_reset;
    drive(1'b0, 0, 0, 0, 0, 0, 0, 0, 0);
    testsRun++;
    if (ctl !== RSTOUT) begin
      testsFailed++;
      $display("FAIL reset_outputs: got %b expected %b", ctl, RSTOUT);
    end
    drive(1'b1, 0, 0, 0, 0, 0, 0, 0, 0);
    testsRun++;
    if (ctl !== NORMAL) begin
      testsFailed++;
      $display("FAIL post_reset_idle: got %b expected %b", ctl, NORMAL);
    end
  endtask

  task automatic test_load_use;
    drive(1'b1, 5, 1, 1, 5, 1, 0, 0, 0);
    testsRun++;
    if (ctl !== STALL) begin
      testsFailed++;
      $display("FAIL load_use_rs1: got %b expected %b", ctl, STALL);
    end
    drive(1'b1, 5, 1, 1, 5, 0, 0, 0, 0);
    testsRun++;
    if (ctl !== NORMAL) begin
      testsFailed++;
      $display("FAIL load_use_release: got %b expected %b", ctl, NORMAL);
    end
    drive(1'b1, 1, 7, 1, 7, 1, 0, 0, 0);
    testsRun++;
    if (ctl !== STALL) begin
      testsFailed++;
      $display("FAIL load_use_rs2: got %b expected %b", ctl, STALL);
    end
  endtask

  task automatic test_no_hazard;
    drive(1'b1, 0, 0, 1, 0, 1, 0, 0, 0);
    testsRun++;
    if (ctl !== NORMAL) begin
      testsFailed++;
      $display("FAIL x0_dest: got %b expected %b", ctl, NORMAL);
    end
    drive(1'b1, 1, 5, 0, 5, 1, 0, 0, 0);
    testsRun++;
    if (ctl !== NORMAL) begin
      testsFailed++;
      $display("FAIL rs2_unused: got %b expected %b", ctl, NORMAL);
    end
    drive(1'b1, 5, 5, 1, 5, 0, 0, 0, 0);
    testsRun++;
    if (ctl !== NORMAL) begin
      testsFailed++;
      $display("FAIL not_a_load: got %b expected %b", ctl, NORMAL);
    end
  endtask

  task automatic test_branch_load_use;
    drive(1'b1, 5, 1, 1, 5, 1, 1, 0, 0);
    testsRun++;
    if (ctl !== FLUSH) begin
      testsFailed++;
      $display("FAIL branch_over_load_use: got %b expected %b", ctl, FLUSH);
    end
  endtask

  task automatic test_mem_wait;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 0, 0, 0, 0, 0, (i == 2), 1, 0);
      testsRun++;
      if (ctl !== FREEZE) begin
        testsFailed++;
        $display("FAIL mem_wait_freeze_%0d: got %b expected %b", i, ctl, FREEZE);
      end
    end
    drive(1'b1, 0, 0, 0, 0, 0, 1, 1, 1);
    testsRun++;
    if (ctl !== FLUSH) begin
      testsFailed++;
      $display("FAIL mem_release_branch: got %b expected %b", ctl, FLUSH);
    end
    drive(1'b1, 0, 0, 0, 0, 0, 0, 1, 1);
    testsRun++;
    if (ctl !== NORMAL) begin
      testsFailed++;
      $display("FAIL mem_ready_same_cycle: got %b expected %b", ctl, NORMAL);
    end
    drive(1'b1, 0, 0, 0, 0, 0, 0, 0, 0);
    testsRun++;
    if (ctl !== NORMAL) begin
      testsFailed++;
      $display("FAIL mem_idle_after: got %b expected %b", ctl, NORMAL);
    end
  endtask

  task automatic test_timeout;
    // One RUN cycle plus four WAIT cycles stay frozen without the error flag.
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 0, 0, 0, 0, 0, 0, 1, 0);
      testsRun++;
      if (ctl !== FREEZE) begin
        testsFailed++;
        $display("FAIL timeout_pre_%0d: got %b expected %b", i, ctl, FREEZE);
      end
    end
    drive(1'b1, 0, 0, 0, 0, 0, 0, 1, 0);
    testsRun++;
    if (ctl !== ERROUT) begin
      testsFailed++;
      $display("FAIL timeout_set: got %b expected %b", ctl, ERROUT);
    end
    drive(1'b1, 0, 0, 0, 0, 0, 0, 1, 1);
    testsRun++;
    if (ctl !== ERROUT) begin
      testsFailed++;
      $display("FAIL timeout_sticky_ready: got %b expected %b", ctl, ERROUT);
    end
    drive(1'b1, 5, 1, 1, 5, 1, 1, 0, 0);
    testsRun++;
    if (ctl !== ERROUT) begin
      testsFailed++;
      $display("FAIL err_blocks_branch: got %b expected %b", ctl, ERROUT);
    end
    drive(1'b0, 0, 0, 0, 0, 0, 0, 0, 0);
    testsRun++;
    if (ctl !== (RSTOUT | 7'b0000001)) begin
      testsFailed++;
      $display("FAIL err_reset_cycle: got %b expected %b", ctl, RSTOUT | 7'b0000001);
    end
    drive(1'b1, 0, 0, 0, 0, 0, 0, 0, 0);
    testsRun++;
    if (ctl !== NORMAL) begin
      testsFailed++;
      $display("FAIL err_cleared: got %b expected %b", ctl, NORMAL);
    end
  endtask

`ifdef HDU_PERF_CNT_EN
  task automatic test_perf_counters;
    drive(1'b0, 0, 0, 0, 0, 0, 0, 0, 0);
    drive(1'b1, 0, 0, 0, 0, 0, 0, 0, 0);
    drive(1'b1, 5, 1, 1, 5, 1, 0, 0, 0);
    drive(1'b1, 0, 0, 0, 0, 0, 0, 0, 0);
    drive(1'b1, 3, 5, 1, 5, 1, 0, 0, 0);
    drive(1'b1, 0, 0, 0, 0, 0, 0, 0, 0);
    drive(1'b1, 0, 0, 0, 0, 0, 1, 0, 0);
    drive(1'b1, 0, 0, 0, 0, 0, 0, 0, 0);
    testsRun++;
    if (stallCycles !== 32'd2) begin
      testsFailed++;
      $display("FAIL perf_stall_cycles: got %0d expected 2", stallCycles);
    end
    testsRun++;
    if (flushCount !== 32'd1) begin
      testsFailed++;
      $display("FAIL perf_flush_count: got %0d expected 1", flushCount);
    end
  endtask
`endif

  initial begin
    rstn = 1'b0;
    ifidRs1 = '0; ifidRs2 = '0; idexRd = '0;
    ifidUsesRs2 = 1'b0; idexMemRead = 1'b0; exBranchTaken = 1'b0;
    exmemMemReq = 1'b0; dmemReady = 1'b0;
    test_reset();
    test_load_use();
    test_no_hazard();
    test_branch_load_use();
    test_mem_wait();
    test_timeout();
`ifdef HDU_PERF_CNT_EN
    test_perf_counters();
`endif
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/hdu.md
# hdu

Hazard detection and pipeline-control unit for the RV32I five-stage core. It is the stall/flush counterpart to the forwarding unit and handles the hazards that forwarding cannot resolve: load-use dependencies, taken-branch redirects and data-memory wait states. It drives the write-enables, bubble inserts and flushes of the PC and the IF/ID, ID/EX and EX/MEM registers. A watchdog latches a sticky error if a data-memory access never completes.

## Interface
Parameters:
- MEM_TIMEOUT, 255: maximum consecutive data-memory wait cycles before the unit declares a timeout. Legal range is 1..65535.

Ports:
- clk  in  1  core clock; all state updates on the rising edge
- rstn  in  1  synchronous, active-low reset
- ifidRs1, ifidRs2  in  `RF_ADDR_WIDTH  source registers of the instruction in ID
- ifidUsesRs2  in  1  instruction in ID reads rs2 (R-type, S-type, B-type)
- idexRd  in  `RF_ADDR_WIDTH  destination register of the instruction in EX
- idexMemRead  in  1  instruction in EX is a load
- exBranchTaken  in  1  branch or jump resolved taken in EX
- exmemMemReq  in  1  instruction in MEM accesses data memory
- dmemReady  in  1  data memory completes the access this cycle
- pcWrite  out  1  PC register enable
- ifidWrite  out  1  IF/ID register enable
- idexBubble  out  1  load a NOP (all control bits 0) into ID/EX
- ifidFlush, idexFlush  out  1  load a NOP into IF/ID and into ID/EX
- pipeFreeze  out  1  hold ID/EX and EX/MEM, and load a NOP into MEM/WB
- memTimeout  out  1  sticky error flag
- stallCycles, flushCount  out  32  performance counters (present only when HDU_PERF_CNT_EN is defined)

## Operation
Derived signals:
- memBusy = exmemMemReq && !dmemReady
- loadUse = idexMemRead && idexRd != 0 && (idexRd == ifidRs1 || (ifidUsesRs2 && idexRd == ifidRs2))

State machine (2-bit) with a 16-bit wait counter waitCnt:
- RUN:
  - If memBusy: go to WAIT and set waitCnt = 1.
  - Otherwise stay in RUN.
- WAIT:
  - If dmemReady: go to RUN and set waitCnt = 0.
  - Else if waitCnt == MEM_TIMEOUT: go to ERR and set memTimeout = 1.
  - Otherwise increment waitCnt.
- ERR:
  - Terminal state; only reset leaves it.
  - All enables stay low and pipeFreeze = 1.

Output priority, evaluated every cycle from the current inputs and state:
1. ERR, or memBusy in any state: pipeFreeze = 1, pcWrite = 0, ifidWrite = 0. No flush or bubble is asserted. A taken branch or load-use hazard pending in EX is held and re-evaluated once the freeze releases.
2. exBranchTaken: ifidFlush = 1, idexFlush = 1, pcWrite = 1, ifidWrite = 1. Any load-use hazard is ignored, because the dependent instruction is being flushed.
3. loadUse: pcWrite = 0, ifidWrite = 0, idexBubble = 1. This lasts exactly one cycle; the bubble clears idexMemRead, which ends the condition.
4. Otherwise: pcWrite = 1, ifidWrite = 1, and all other control outputs are 0.

Other rules:
- Register x0 never causes a hazard.
- A freeze must not lose the memory request: exmemMemReq stays asserted because EX/MEM is held.

## Timing
- All control outputs are combinational from the inputs plus the registered state, with zero-cycle latency. They are valid in the same cycle as the hazard.
- State, waitCnt, memTimeout and the counters update on the rising edge of clk.
- While rstn = 0 (sampled at the edge, and the following cycle reflects it):
  - state = RUN, waitCnt = 0, memTimeout = 0, counters = 0.
  - Combinational outputs are forced to pcWrite = 0, ifidWrite = 0, ifidFlush = 1, idexFlush = 1, idexBubble = 0, pipeFreeze = 0.
- Reset asserted mid-WAIT or in ERR returns the unit to RUN on the next edge.
- dmemReady in the same cycle as the request produces no freeze and no state change.
- With MEM_TIMEOUT = N, the first freeze cycle is counted as 1, and memTimeout rises on the edge after the Nth consecutive not-ready cycle in WAIT.

## Configuration
- HDU_PERF_CNT_EN defined:
  - stallCycles increments every cycle in which pcWrite = 0 and rstn = 1.
  - flushCount increments every cycle in which ifidFlush = 1 and rstn = 1.
  - Both are 32-bit counters that wrap from 0xFFFFFFFF to 0.
- HDU_PERF_CNT_EN undefined: both ports and their registers are absent.

## Test plan
- Load-use: `lw x5` in EX, `add x6,x5,x1` in ID -> exactly one cycle with pcWrite = 0, ifidWrite = 0, idexBubble = 1; the next cycle returns to the normal outputs.
- x0 destination and unused rs2: idexRd = 0, or rs2 matches with ifidUsesRs2 = 0 -> no stall.
- Branch and load-use together: exBranchTaken = 1 with loadUse true -> ifidFlush = idexFlush = 1, idexBubble = 0, pcWrite = 1.
- Memory wait: exmemMemReq = 1 with dmemReady low for 3 cycles -> pipeFreeze = 1 for those 3 cycles, released in the cycle dmemReady = 1, state back to RUN, waitCnt = 0. A branch taken during the freeze is flushed only after the release.
- Timeout with MEM_TIMEOUT = 4 and dmemReady held low -> memTimeout = 1 after the 4th wait cycle and stays set after dmemReady rises. Asserting rstn = 0 for one cycle clears it.
- HDU_PERF_CNT_EN: 2 load-use stalls plus 1 branch -> stallCycles = 2, flushCount = 1. Preloading stallCycles to 0xFFFFFFFF and applying one more stall wraps it to 0.
